reg_file_arb: RTL and testbench
===============================

Name: reg_file_arb

Overview:
- Two-port arbiter that shares the single-command register file between the decode stage (requester 0) and the writeback stage (requester 1).
- Accepts one command at a time from the winning requester and forwards it over the register file's valid/ready command handshake.
- Collects the register file's result over its res_valid/res_ready handshake and returns it to the original requester only.
- Command encoding (READ=0, WRITE=1, MARKD=2, CHECK=3) is opaque to the arbiter and passed through unmodified.

Parameters:
- DATA_WIDTH, 32, width of data/result buses
- CMD_WIDTH, 2, width of command field
- REG_WIDTH, 4, width of register index

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req0_reg / i_req1_reg  in  REG_WIDTH  register index per requester
- i_req0_data / i_req1_data  in  DATA_WIDTH  write data per requester
- i_req0_cmd / i_req1_cmd  in  CMD_WIDTH  command per requester
- i_req0_valid / i_req1_valid  in  1  command valid
- o_req0_ready / o_req1_ready  out  1  command accepted this cycle
- o_req0_data / o_req1_data  out  DATA_WIDTH  result data
- o_req0_res_valid / o_req1_res_valid  out  1  result valid
- i_req0_res_ready / i_req1_res_ready  in  1  requester takes result
- o_rf_reg  out  REG_WIDTH  forwarded index
- o_rf_data  out  DATA_WIDTH  forwarded write data
- o_rf_cmd  out  CMD_WIDTH  forwarded command
- o_rf_valid  out  1  forwarded command valid
- i_rf_ready  in  1  register file ready
- i_rf_data  in  DATA_WIDTH  register file result
- i_rf_res_valid  in  1  register file result valid
- o_rf_res_ready  out  1  arbiter takes result
- o_busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- FSM states:
  - IDLE: grant computed combinationally. o_reqN_ready = (state==IDLE) && grant==N && i_reqN_valid. On accept, latch reg/data/cmd and grant id, then go to ISSUE.
  - ISSUE: o_rf_valid=1 with latched fields held stable. On i_rf_ready at a clock edge, go to WAIT_RES.
  - WAIT_RES: o_rf_res_ready=1. On i_rf_res_valid, capture i_rf_data into the result register and go to RETURN. i_rf_data is ignored in all other cycles, since it is undefined outside res_valid.
  - RETURN: o_reqG_res_valid=1 for granted requester G only; o_reqG_data = captured result. On i_reqG_res_ready, go to IDLE and set last_grant=G.
- Arbitration is round-robin.
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
- Minimum latency is 4 cycles, accept to result handshake, when the register file and requester respond immediately. At most one transaction is in flight.
- Non-granted outputs: o_reqN_data=0 and o_reqN_res_valid=0 for the non-granted requester. o_rf_valid=0 outside ISSUE. o_rf_res_ready=0 outside WAIT_RES.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), all valid/ready outputs 0, all data outputs 0, o_busy=0.
- Reset mid-operation: the in-flight transaction is dropped and no result is returned. The register file is reset in the same cycle by the system, so no orphan result is expected.
- A requester deasserting valid before accept: no effect. Fields are latched only at accept.
- Requester N must not reissue until its own result handshake completes. This is not checked.

Optional Feature:
- Macro REG_ARB_WB_PRIO_EN.
- Defined: fixed priority. Requester 1 (writeback) always wins when both are valid, so writes retire and clear dirty marks ahead of decode reads/checks. last_grant is still maintained but is unused for arbitration.
- Undefined: round-robin as above.

Test Plan:
- Single read: req0 READ reg 0 while rf returns 0x0000_1234 -> o_req0_res_valid=1, o_req0_data=0x0000_1234, o_req1_res_valid stays 0, 4 cycles.
- Tie after reset: both valid (req0 CHECK reg 2, req1 WRITE reg 3 data 0xDEAD_BEEF) -> req0 served first, then req1. The rf sees cmd 3 then cmd 1 with data 0xDEAD_BEEF.
- Round-robin: both held valid for 4 transactions -> grant order 0,1,0,1. With REG_ARB_WB_PRIO_EN -> 1,1,1,1.
- Backpressure: i_rf_ready low 3 cycles in ISSUE -> o_rf_valid and o_rf_reg/cmd/data stable. Also i_req0_res_ready low 2 cycles -> result held stable, o_busy=1, no new accept.
- Reset mid-WAIT_RES: assert reset -> next cycle state IDLE, all res_valid 0, o_busy 0. A new req1 READ afterwards completes normally.

Source files
------------

// File: rtl/reg_file_arb.sv
// reg_file_arb: shares one single-command register file between the decode
// stage (requester 0) and the writeback stage (requester 1). One transaction
// is in flight at a time: accept -> issue to the register file -> wait for its
// result -> return the result to the requester that issued the command.
//
// Optional feature macro: REG_ARB_WB_PRIO_EN
//   defined   : requester 1 (writeback) always wins a tie (fixed priority)
//   undefined : round-robin, the requester that was not granted last wins a tie
//
// Handshake contract (applies to every valid/ready pair on this block):
// a transfer happens on a rising clk edge where valid and ready are both 1.
// A valid source holds its payload stable until that edge. The arbiter only
// asserts its own ready/valid outputs from the current state, never from a
// combinational path through another ready of the same channel.
module reg_file_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 2,
    parameter int REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_WIDTH-1:0]  i_req0_reg,
    input  logic [REG_WIDTH-1:0]  i_req1_reg,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    input  logic [CMD_WIDTH-1:0]  i_req0_cmd,
    input  logic [CMD_WIDTH-1:0]  i_req1_cmd,
    input  logic                  i_req0_valid,
    input  logic                  i_req1_valid,
    output logic                  o_req0_ready,
    output logic                  o_req1_ready,
    output logic [DATA_WIDTH-1:0] o_req0_data,
    output logic [DATA_WIDTH-1:0] o_req1_data,
    output logic                  o_req0_res_valid,
    output logic                  o_req1_res_valid,
    input  logic                  i_req0_res_ready,
    input  logic                  i_req1_res_ready,
    output logic [REG_WIDTH-1:0]  o_rf_reg,
    output logic [DATA_WIDTH-1:0] o_rf_data,
    output logic [CMD_WIDTH-1:0]  o_rf_cmd,
    output logic                  o_rf_valid,
    input  logic                  i_rf_ready,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    input  logic                  i_rf_res_valid,
    output logic                  o_rf_res_ready,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_RETURN   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;            // requester owning the transaction
    logic                  last_grant_q, last_grant_d;  // requester served most recently
    logic [REG_WIDTH-1:0]  reg_q, reg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  arb_grant;                   // tie/single winner while idle
    logic                  accept0, accept1;

    // Pick the winner among the currently valid requesters.
    always_comb begin
        arb_grant = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
`ifdef REG_ARB_WB_PRIO_EN
            arb_grant = 1'b1;
`else
            arb_grant = ~last_grant_q;
`endif
        end else if (i_req1_valid) begin
            arb_grant = 1'b1;
        end
    end

    // Next-state and output decode for the transaction FSM.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        reg_d            = reg_q;
        data_d           = data_q;
        cmd_d            = cmd_q;
        res_d            = res_q;
        accept0          = 1'b0;
        accept1          = 1'b0;
        o_req0_ready     = 1'b0;
        o_req1_ready     = 1'b0;
        o_req0_res_valid = 1'b0;
        o_req1_res_valid = 1'b0;
        o_req0_data      = '0;
        o_req1_data      = '0;
        o_rf_valid       = 1'b0;
        o_rf_res_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept0      = i_req0_valid && !arb_grant;
                accept1      = i_req1_valid && arb_grant;
                o_req0_ready = accept0;
                o_req1_ready = accept1;
                if (accept1) begin
                    grant_d = 1'b1;
                    reg_d   = i_req1_reg;
                    data_d  = i_req1_data;
                    cmd_d   = i_req1_cmd;
                    state_d = S_ISSUE;
                end else if (accept0) begin
                    grant_d = 1'b0;
                    reg_d   = i_req0_reg;
                    data_d  = i_req0_data;
                    cmd_d   = i_req0_cmd;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_rf_valid = 1'b1;
                if (i_rf_ready) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                // i_rf_data is only meaningful alongside i_rf_res_valid.
                o_rf_res_ready = 1'b1;
                if (i_rf_res_valid) begin
                    res_d   = i_rf_data;
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                if (grant_q) begin
                    o_req1_res_valid = 1'b1;
                    o_req1_data      = res_q;
                    if (i_req1_res_ready) begin
                        last_grant_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end else begin
                    o_req0_res_valid = 1'b1;
                    o_req0_data      = res_q;
                    if (i_req0_res_ready) begin
                        last_grant_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The latched command is presented to the register file for the whole ISSUE phase.
    assign o_rf_reg  = reg_q;
    assign o_rf_data = data_q;
    assign o_rf_cmd  = cmd_q;
    assign o_busy    = (state_q != S_IDLE);

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            reg_q        <= '0;
            data_q       <= '0;
            cmd_q        <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            cmd_q        <= cmd_d;
            res_q        <= res_d;
        end
    end

endmodule

// File: tb/tb_reg_file_arb.sv
// Testbench for reg_file_arb: a behavioural register file responder, per-
// requester result scoreboards and a forwarded-command scoreboard.
module tb_reg_file_arb;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int RW = 4;
    localparam int PW = CW + RW + DW;

    logic          clk;
    logic          reset;
    logic [RW-1:0] i_req0_reg, i_req1_reg;
    logic [DW-1:0] i_req0_data, i_req1_data;
    logic [CW-1:0] i_req0_cmd, i_req1_cmd;
    logic          i_req0_valid, i_req1_valid;
    logic          o_req0_ready, o_req1_ready;
    logic [DW-1:0] o_req0_data, o_req1_data;
    logic          o_req0_res_valid, o_req1_res_valid;
    logic          i_req0_res_ready, i_req1_res_ready;
    logic [RW-1:0] o_rf_reg;
    logic [DW-1:0] o_rf_data;
    logic [CW-1:0] o_rf_cmd;
    logic          o_rf_valid;
    logic          i_rf_ready;
    logic [DW-1:0] i_rf_data;
    logic          i_rf_res_valid;
    logic          o_rf_res_ready;
    logic          o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rf_stall     = 0;
    int rf_res_delay = 0;

    logic [PW-1:0] rf_exp_q[$];
    logic [DW-1:0] res0_exp_q[$];
    logic [DW-1:0] res1_exp_q[$];

    reg_file_arb #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .REG_WIDTH(RW)) dut (
        .clk(clk), .reset(reset),
        .i_req0_reg(i_req0_reg), .i_req1_reg(i_req1_reg),
        .i_req0_data(i_req0_data), .i_req1_data(i_req1_data),
        .i_req0_cmd(i_req0_cmd), .i_req1_cmd(i_req1_cmd),
        .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .o_req0_data(o_req0_data), .o_req1_data(o_req1_data),
        .o_req0_res_valid(o_req0_res_valid), .o_req1_res_valid(o_req1_res_valid),
        .i_req0_res_ready(i_req0_res_ready), .i_req1_res_ready(i_req1_res_ready),
        .o_rf_reg(o_rf_reg), .o_rf_data(o_rf_data), .o_rf_cmd(o_rf_cmd),
        .o_rf_valid(o_rf_valid), .i_rf_ready(i_rf_ready),
        .i_rf_data(i_rf_data), .i_rf_res_valid(i_rf_res_valid),
        .o_rf_res_ready(o_rf_res_ready), .o_busy(o_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // Result the behavioural register file returns for a command.
    function automatic logic [DW-1:0] rf_fn(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                            input logic [DW-1:0] d);
        case (c)
            2'd0:    rf_fn = 32'h0000_1234 + {16'h0, r, 12'h000};
            2'd1:    rf_fn = d ^ 32'h5A5A_0000;
            2'd2:    rf_fn = 32'hA000_0000 | {28'h0, r};
            default: rf_fn = ~d ^ {28'h0, r};
        endcase
    endfunction

    // ---------------- register file responder + command scoreboard ----------------
    initial begin : rf_model
        logic [DW-1:0] pend_res;
        logic [PW-1:0] got, exp;
        bit pend, cmd_fire, res_fire, rst_seen;
        int res_wait;
        pend = 0;
        res_wait = 0;
        pend_res = '0;
        i_rf_ready = 1'b1;
        i_rf_res_valid = 1'b0;
        i_rf_data = '0;
        forever begin
            @(negedge clk);
            rst_seen = reset;
            cmd_fire = o_rf_valid && i_rf_ready && !reset;
            res_fire = o_rf_res_ready && i_rf_res_valid && !reset;
            if (o_rf_valid && !i_rf_ready && rf_stall > 0) rf_stall--;
            if (cmd_fire) begin
                got = {o_rf_cmd, o_rf_reg, o_rf_data};
                n_cmp++;
                if (rf_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rf_cmd unexpected: got %h, required none", got);
                end else begin
                    exp = rf_exp_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL rf_cmd: got %h, required %h", got, exp);
                    end
                end
                pend = 1;
                pend_res = rf_fn(o_rf_cmd, o_rf_reg, o_rf_data);
                res_wait = rf_res_delay;
            end
            @(posedge clk);
            #1;
            if (rst_seen) begin
                pend = 0;
                i_rf_res_valid = 1'b0;
            end else begin
                if (res_fire) i_rf_res_valid = 1'b0;
                if (pend) begin
                    if (res_wait == 0) begin
                        i_rf_res_valid = 1'b1;
                        i_rf_data = pend_res;
                        pend = 0;
                    end else begin
                        res_wait--;
                    end
                end
            end
            if (!i_rf_res_valid) i_rf_data = $urandom;
            i_rf_ready = (rf_stall == 0);
        end
    end

    // ---------------- result scoreboards ----------------
    initial begin : res_monitor
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (o_req0_res_valid) begin
                    n_cmp++;
                    if (o_req1_res_valid !== 1'b0 || o_req1_data !== '0) begin
                        n_err++;
                        $display("FAIL excl_req1: got valid=%b data=%h, required 0/0",
                                 o_req1_res_valid, o_req1_data);
                    end
                end
                if (o_req1_res_valid) begin
                    n_cmp++;
                    if (o_req0_res_valid !== 1'b0 || o_req0_data !== '0) begin
                        n_err++;
                        $display("FAIL excl_req0: got valid=%b data=%h, required 0/0",
                                 o_req0_res_valid, o_req0_data);
                    end
                end
                if (o_req0_res_valid && i_req0_res_ready) begin
                    n_cmp++;
                    if (res0_exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL res0 unexpected: got %h", o_req0_data);
                    end else begin
                        exp = res0_exp_q.pop_front();
                        if (o_req0_data !== exp) begin
                            n_err++;
                            $display("FAIL res0: got %h, required %h", o_req0_data, exp);
                        end
                    end
                end
                if (o_req1_res_valid && i_req1_res_ready) begin
                    n_cmp++;
                    if (res1_exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL res1 unexpected: got %h", o_req1_data);
                    end else begin
                        exp = res1_exp_q.pop_front();
                        if (o_req1_data !== exp) begin
                            n_err++;
                            $display("FAIL res1: got %h, required %h", o_req1_data, exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int n, input logic v, input logic [CW-1:0] c,
                         input logic [RW-1:0] r, input logic [DW-1:0] d);
        if (n == 0) begin
            i_req0_valid = v; i_req0_cmd = c; i_req0_reg = r; i_req0_data = d;
        end else begin
            i_req1_valid = v; i_req1_cmd = c; i_req1_reg = r; i_req1_data = d;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Issue one command from requester n and wait for its result handshake.
    task automatic do_req(input int n, input logic [CW-1:0] c, input logic [RW-1:0] r,
                          input logic [DW-1:0] d, output int lat);
        int t0;
        bit ok;
        lat = -1;
        @(posedge clk);
        #1;
        drive(n, 1'b1, c, r, d);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((n == 0) ? o_req0_ready : o_req1_ready) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout req%0d: got no ready, required ready", n);
            drive(n, 1'b0, c, r, d);
            return;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        drive(n, 1'b0, CW'($urandom), RW'($urandom), $urandom);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((n == 0) ? (o_req0_res_valid && i_req0_res_ready)
                         : (o_req1_res_valid && i_req1_res_ready)) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL result_timeout req%0d: got no res_valid, required res_valid", n);
            return;
        end
        lat = cyc - t0 + 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [PW+7:0] got;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {o_req0_ready, o_req1_ready, o_req0_res_valid, o_req1_res_valid,
               o_rf_valid, o_rf_res_ready, o_busy, 1'b0, o_rf_cmd, o_rf_reg, o_rf_data};
        n_cmp++;
        if (got !== '0 || o_req0_data !== '0 || o_req1_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%h/%h, required all 0", got, o_req0_data, o_req1_data);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        int l0, l1;
        apply_reset();
`ifdef REG_ARB_WB_PRIO_EN
        rf_exp_q.push_back({2'd1, 4'd3, 32'hDEAD_BEEF});
        rf_exp_q.push_back({2'd3, 4'd2, 32'h1111_0000});
`else
        rf_exp_q.push_back({2'd3, 4'd2, 32'h1111_0000});
        rf_exp_q.push_back({2'd1, 4'd3, 32'hDEAD_BEEF});
`endif
        res0_exp_q.push_back(rf_fn(2'd3, 4'd2, 32'h1111_0000));
        res1_exp_q.push_back(rf_fn(2'd1, 4'd3, 32'hDEAD_BEEF));
        fork
            do_req(0, 2'd3, 4'd2, 32'h1111_0000, l0);
            do_req(1, 2'd1, 4'd3, 32'hDEAD_BEEF, l1);
        join
    endtask

    task automatic test_single_read();
        int lat;
        rf_exp_q.push_back({2'd0, 4'd0, 32'h0});
        res0_exp_q.push_back(32'h0000_1234);
        do_req(0, 2'd0, 4'd0, 32'h0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL single_read_latency: got %0d cycles, required 4", lat);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
`ifdef REG_ARB_WB_PRIO_EN
        for (int i = 0; i < 4; i++) rf_exp_q.push_back({2'd1, RW'(8 + i), 32'hC000_0000 + DW'(i)});
        for (int i = 0; i < 4; i++) rf_exp_q.push_back({2'd0, RW'(i), 32'h0});
`else
        for (int i = 0; i < 4; i++) begin
            rf_exp_q.push_back({2'd0, RW'(i), 32'h0});
            rf_exp_q.push_back({2'd1, RW'(8 + i), 32'hC000_0000 + DW'(i)});
        end
`endif
        for (int i = 0; i < 4; i++) begin
            res0_exp_q.push_back(rf_fn(2'd0, RW'(i), 32'h0));
            res1_exp_q.push_back(rf_fn(2'd1, RW'(8 + i), 32'hC000_0000 + DW'(i)));
        end
        fork
            begin
                int l0;
                for (int i = 0; i < 4; i++) do_req(0, 2'd0, RW'(i), 32'h0, l0);
            end
            begin
                int l1;
                for (int j = 0; j < 4; j++) do_req(1, 2'd1, RW'(8 + j), 32'hC000_0000 + DW'(j), l1);
            end
        join
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_cmd;
        logic [DW-1:0] exp_res;
        bit ok;
        exp_cmd = {2'd2, 4'd7, 32'h0BAD_F00D};
        exp_res = rf_fn(2'd2, 4'd7, 32'h0BAD_F00D);
        rf_exp_q.push_back(exp_cmd);
        res0_exp_q.push_back(exp_res);
        @(negedge clk);
        rf_stall = 3;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 2'd2, 4'd7, 32'h0BAD_F00D);
        i_req0_res_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_req0_ready) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_accept: got no ready, required ready"); end
        @(posedge clk);
        #1;
        drive(0, 1'b0, CW'($urandom), RW'($urandom), $urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({o_rf_valid, o_rf_cmd, o_rf_reg, o_rf_data} !== {1'b1, exp_cmd}) begin
                n_err++;
                $display("FAIL bp_issue_hold[%0d]: got %b/%h, required 1/%h", i, o_rf_valid,
                         {o_rf_cmd, o_rf_reg, o_rf_data}, exp_cmd);
            end
        end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_req0_res_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_result_timeout: got no res_valid, required res_valid"); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({o_req0_res_valid, o_busy, o_req1_ready} !== 3'b110 || o_req0_data !== exp_res) begin
                n_err++;
                $display("FAIL bp_result_hold[%0d]: got v/busy/rdy1=%b%b%b data=%h, required 110/%h",
                         i, o_req0_res_valid, o_busy, o_req1_ready, o_req0_data, exp_res);
            end
            @(posedge clk);
            #1;
            if (i == 0) drive(1, 1'b1, 2'd0, 4'd1, 32'h0);
            else begin
                i_req0_res_ready = 1'b1;
                drive(1, 1'b0, 2'd0, 4'd1, 32'h0);
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_rf_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_after: got busy/rf_valid=%b%b, required 00", o_busy, o_rf_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        rf_exp_q.push_back({2'd0, 4'd9, 32'h0});
        @(negedge clk);
        rf_res_delay = 6;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 2'd0, 4'd9, 32'h0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_req0_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 2'd0, 4'd0, 32'h0);
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (o_rf_res_ready) begin ok = 1; break; end
            end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rm_wait_res: got no rf_res_ready, required rf_res_ready"); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rf_res_delay = 0;
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_req0_res_valid, o_req1_res_valid, o_rf_valid, o_rf_res_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL rm_after_reset: got %b%b%b%b%b, required 00000", o_busy,
                     o_req0_res_valid, o_req1_res_valid, o_rf_valid, o_rf_res_ready);
        end
        rf_exp_q.push_back({2'd0, 4'd5, 32'h0});
        res1_exp_q.push_back(rf_fn(2'd0, 4'd5, 32'h0));
        do_req(1, 2'd0, 4'd5, 32'h0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL rm_new_req_latency: got %0d cycles, required 4", lat);
        end
    endtask

    task automatic test_drain();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rf_exp_q.size() != 0 || res0_exp_q.size() != 0 || res1_exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d/%0d pending, required 0/0/0",
                     rf_exp_q.size(), res0_exp_q.size(), res1_exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 2'd0, 4'd0, 32'h0);
        drive(1, 1'b0, 2'd0, 4'd0, 32'h0);
        i_req0_res_ready = 1'b1;
        i_req1_res_ready = 1'b1;
        test_reset();
        test_tie_after_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
